// File: rtl/window_pkg.sv
// Shared encodings for the window actuator model and the window controller
// that talks to it: FSM states plus cmd/sense bit positions.
package window_pkg;

  typedef enum logic [1:0] {
    STOPPED,
    MOVING_UP,
    MOVING_DOWN,
    DEADTIME
  } state_t;

  // cmd bus bit positions
  localparam int CMD_UP    = 0;
  localparam int CMD_DN    = 1;
  localparam int CMD_BRAKE = 2;

  // sense bus bit positions
  localparam int SNS_TOP   = 0;
  localparam int SNS_BOT   = 1;
  localparam int SNS_PINCH = 2;

endpackage

// File: rtl/window_step_timer.sv
// Loadable down-counter. While enabled it counts down to zero, raises tc
// for the cycle it sits at zero, and reloads itself on that edge so it can
// free-run as a periodic tick.
module window_step_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] cnt;

  assign tc = en && (cnt == '0);

  // load has priority; an enabled zero count wraps back to load_val
  always_ff @(posedge clk) begin
    if (rst)       cnt <= '0;
    else if (load) cnt <= load_val;
    else if (en)   cnt <= (cnt == '0) ? load_val : cnt - 1'b1;
  end

endmodule

// File: rtl/window_actuator_model.sv
// Behavioural window motor + sensor model. Accepts the controller's
// up/down/brake command, drives a prescaled position counter, enforces a
// dead time on reversals and latches a pinch on an obstacle while closing.
// All outputs come straight from registers.
module window_actuator_model
  import window_pkg::*;
#(
  parameter int TRAVEL   = 255,
  parameter int STEP_DIV = 4,
  parameter int DEAD     = 3,
  parameter int INIT_POS = 0,
  localparam int PW      = $clog2(TRAVEL + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    cmd,
  input  logic          obstacle,
  output logic [2:0]    sense,
  output logic [PW-1:0] pos,
  output logic          motor_up,
  output logic          motor_dn
);

  localparam int TW = $clog2(STEP_DIV + 1);
  localparam int DW = $clog2(DEAD + 1);

  state_t        state, state_nxt;
  logic [PW-1:0] pos_nxt;
  logic          pinch, pinch_nxt;
  logic          pend_up, pend_up_nxt;  // direction to resume after dead time
  logic          presc_load, presc_tc;
  logic          dead_load, dead_tc;
  logic          req_up, req_dn, brake, at_top, at_bot;

  assign req_up = cmd[CMD_UP] & ~cmd[CMD_DN];
  assign req_dn = cmd[CMD_DN] & ~cmd[CMD_UP];
  assign brake  = cmd[CMD_BRAKE];
  assign at_top = (pos == PW'(TRAVEL));
  assign at_bot = (pos == '0);

  window_step_timer #(.W(TW)) u_presc (
    .clk      (clk),
    .rst      (rst),
    .load     (presc_load),
    .en       ((state == MOVING_UP) || (state == MOVING_DOWN)),
    .load_val (TW'(STEP_DIV - 1)),
    .tc       (presc_tc)
  );

  window_step_timer #(.W(DW)) u_dead (
    .clk      (clk),
    .rst      (rst),
    .load     (dead_load),
    .en       (state == DEADTIME),
    .load_val (DW'(DEAD - 1)),
    .tc       (dead_tc)
  );

  // State register plus the position and pinch latches
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= STOPPED;
      pos     <= PW'(INIT_POS);
      pinch   <= 1'b0;
      pend_up <= 1'b0;
    end else begin
      state   <= state_nxt;
      pos     <= pos_nxt;
      pinch   <= pinch_nxt;
      pend_up <= pend_up_nxt;
    end
  end

  // Next state: brake > obstacle > limit > direction request.
  // A prescaler tick moves pos even if the request changes on that edge,
  // since the motor was energized for the whole step period.
  always_comb begin
    state_nxt   = state;
    pos_nxt     = pos;
    pinch_nxt   = pinch;
    pend_up_nxt = pend_up;
    presc_load  = 1'b0;
    dead_load   = 1'b0;
    case (state)
      STOPPED: begin
        if (!brake) begin
          if (req_up && !at_top && !pinch) begin
            state_nxt  = MOVING_UP;
            presc_load = 1'b1;
          end else if (req_dn && !at_bot) begin
            state_nxt  = MOVING_DOWN;
            presc_load = 1'b1;
            pinch_nxt  = 1'b0;
          end
        end
      end
      MOVING_UP: begin
        if (brake) begin
          state_nxt = STOPPED;
        end else if (obstacle) begin
          pinch_nxt = 1'b1;
          state_nxt = STOPPED;
        end else begin
          if (presc_tc && !at_top) pos_nxt = pos + 1'b1;
          if (pos_nxt == PW'(TRAVEL)) begin
            state_nxt = STOPPED;
          end else if (req_up) begin
            state_nxt = MOVING_UP;
          end else if (req_dn) begin
            state_nxt   = DEADTIME;
            pend_up_nxt = 1'b0;
            dead_load   = 1'b1;
          end else begin
            state_nxt = STOPPED;
          end
        end
      end
      MOVING_DOWN: begin
        if (brake) begin
          state_nxt = STOPPED;
        end else begin
          if (presc_tc && !at_bot) pos_nxt = pos - 1'b1;
          if (pos_nxt == '0) begin
            state_nxt = STOPPED;
          end else if (req_dn) begin
            state_nxt = MOVING_DOWN;
          end else if (req_up) begin
            state_nxt   = DEADTIME;
            pend_up_nxt = 1'b1;
            dead_load   = 1'b1;
          end else begin
            state_nxt = STOPPED;
          end
        end
      end
      DEADTIME: begin
        if (brake) begin
          state_nxt = STOPPED;
        end else if (dead_tc) begin
          if (pend_up && req_up && !at_top && !pinch) begin
            state_nxt  = MOVING_UP;
            presc_load = 1'b1;
          end else if (!pend_up && req_dn && !at_bot) begin
            state_nxt  = MOVING_DOWN;
            presc_load = 1'b1;
            pinch_nxt  = 1'b0;
          end else begin
            state_nxt = STOPPED;
          end
        end
      end
      default: state_nxt = STOPPED;
    endcase
  end

  // Outputs decoded from registered state, pos and pinch only
  always_comb begin
    motor_up          = (state == MOVING_UP);
    motor_dn          = (state == MOVING_DOWN);
    sense             = '0;
    sense[SNS_TOP]    = at_top;
    sense[SNS_BOT]    = at_bot;
    sense[SNS_PINCH]  = pinch;
  end

endmodule

// File: tb/tb_window_actuator_model.sv
// Bench for window_actuator_model: directed scenarios with literal
// expectations plus sticky random commands, all checked every cycle
// against a direction/age based reference model.
module tb_window_actuator_model;

  localparam int T  = 8;
  localparam int SD = 4;
  localparam int DT = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] cmd = 3'b001;
  logic       obstacle = 1'b0;
  logic [2:0] sense;
  logic [3:0] pos;
  logic       motor_up, motor_dn;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // reference model: dir +1/-1/0, motion age, dead cycles left, pending dir
  int m_pos = 0, m_dir = 0, m_age = 0, m_dead = 0, m_pend = 0;
  bit m_pinch = 1'b0;

  // literal expectations requested by the stimulus process
  int         lit_req = 0, lit_seen = 0;
  string      lit_name;
  int         lit_pos;
  logic [2:0] lit_sns;
  logic       lit_mu, lit_md;

  window_actuator_model #(.TRAVEL(T), .STEP_DIV(SD), .DEAD(DT), .INIT_POS(0)) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd      (cmd),
    .obstacle (obstacle),
    .sense    (sense),
    .pos      (pos),
    .motor_up (motor_up),
    .motor_dn (motor_dn)
  );

  always #5 clk = ~clk;

  // model update on each rising edge from the inputs sampled there
  initial forever begin
    bit up, dn, br;
    @(posedge clk);
    up = cmd[0] && !cmd[1];
    dn = cmd[1] && !cmd[0];
    br = cmd[2];
    if (rst) begin
      m_pos = 0; m_dir = 0; m_age = 0; m_dead = 0; m_pend = 0; m_pinch = 0;
    end else if (m_dead > 0) begin
      if (br) m_dead = 0;
      else begin
        m_dead--;
        if (m_dead == 0) begin
          if (m_pend > 0 && up && m_pos < T) begin m_dir = 1; m_age = 0; end
          else if (m_pend < 0 && dn && m_pos > 0) begin m_dir = -1; m_age = 0; m_pinch = 0; end
        end
      end
    end else if (m_dir == 0) begin
      if (!br) begin
        if (up && m_pos < T && !m_pinch) begin m_dir = 1; m_age = 0; end
        else if (dn && m_pos > 0) begin m_dir = -1; m_age = 0; m_pinch = 0; end
      end
    end else begin
      if (br) m_dir = 0;
      else if (m_dir > 0 && obstacle) begin m_pinch = 1; m_dir = 0; end
      else begin
        m_age++;
        if (m_age % SD == 0) m_pos += m_dir;
        if ((m_dir > 0 && m_pos == T) || (m_dir < 0 && m_pos == 0)) m_dir = 0;
        else if ((m_dir > 0 && up) || (m_dir < 0 && dn)) m_dir = m_dir;
        else if ((m_dir > 0 && dn) || (m_dir < 0 && up)) begin
          m_pend = -m_dir; m_dir = 0; m_dead = DT;
        end else m_dir = 0;
      end
    end
  end

  task automatic cmp(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // compare process, mid-cycle on the falling edge
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      cmp("pos", int'(pos), m_pos);
      cmp("motor_up", int'(motor_up), int'(m_dir > 0));
      cmp("motor_dn", int'(motor_dn), int'(m_dir < 0));
      cmp("sense", int'(sense), int'({m_pinch, m_pos == 0, m_pos == T}));
      cmp("motor_excl", int'(motor_up & motor_dn), 0);
    end
    if (lit_req != lit_seen) begin
      lit_seen = lit_req;
      cmp({lit_name, ".pos"}, int'(pos), lit_pos);
      cmp({lit_name, ".sense"}, int'(sense), int'(lit_sns));
      cmp({lit_name, ".motor_up"}, int'(motor_up), int'(lit_mu));
      cmp({lit_name, ".motor_dn"}, int'(motor_dn), int'(lit_md));
    end
  end

  task automatic cyc(input logic [2:0] c, input logic o);
    cmd = c;
    obstacle = o;
    @(posedge clk);
    #1;
  endtask

  task automatic cycn(input logic [2:0] c, input int n);
    for (int i = 0; i < n; i++) cyc(c, 1'b0);
  endtask

  task automatic expect_lit(input string nm, input int p, input logic [2:0] s,
                            input logic mu, input logic md);
    lit_name = nm; lit_pos = p; lit_sns = s; lit_mu = mu; lit_md = md;
    lit_req++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(3'b001, 1'b0);
    rst = 1'b0;
  endtask

  function automatic logic [2:0] pick();
    logic [2:0] c;
    case ($urandom_range(9))
      0, 1, 2, 3: c = 3'b001;
      4, 5, 6:    c = 3'b010;
      7:          c = 3'b000;
      8:          c = 3'b011;
      default:    c = {1'b1, 2'($urandom_range(3))};
    endcase
    return c;
  endfunction

  initial begin
    logic [2:0] rc;
    // reset held two cycles with an up request pending
    rst = 1'b1;
    cyc(3'b001, 1'b0);
    chk_en = 1'b1;
    cyc(3'b001, 1'b0);
    expect_lit("reset", 0, 3'b010, 1'b0, 1'b0);
    rst = 1'b0;

    // full close
    cyc(3'b001, 1'b0);
    expect_lit("close_start", 0, 3'b010, 1'b1, 1'b0);
    cycn(3'b001, 31);
    expect_lit("close_pos7", 7, 3'b000, 1'b1, 1'b0);
    cyc(3'b001, 1'b0);
    expect_lit("close_top", 8, 3'b001, 1'b0, 1'b0);
    cyc(3'b001, 1'b0);
    expect_lit("up_at_top", 8, 3'b001, 1'b0, 1'b0);

    // reversal from moving up at pos 3
    do_reset();
    cycn(3'b001, 13);
    expect_lit("rev_pos3", 3, 3'b000, 1'b1, 1'b0);
    cyc(3'b001, 1'b0);
    cyc(3'b010, 1'b0);
    expect_lit("rev_dead1", 3, 3'b000, 1'b0, 1'b0);
    cycn(3'b010, 2);
    expect_lit("rev_dead3", 3, 3'b000, 1'b0, 1'b0);
    cyc(3'b010, 1'b0);
    expect_lit("rev_down", 3, 3'b000, 1'b0, 1'b1);
    cycn(3'b010, 3);
    cyc(3'b010, 1'b0);
    expect_lit("rev_step", 2, 3'b000, 1'b0, 1'b1);

    // pinch at pos 5
    do_reset();
    cycn(3'b001, 21);
    expect_lit("pinch_pre", 5, 3'b000, 1'b1, 1'b0);
    cyc(3'b001, 1'b1);
    expect_lit("pinch_hit", 5, 3'b100, 1'b0, 1'b0);
    cycn(3'b001, 3);
    expect_lit("pinch_upign", 5, 3'b100, 1'b0, 1'b0);
    cyc(3'b010, 1'b0);
    expect_lit("pinch_clear", 5, 3'b000, 1'b0, 1'b1);

    // brake and conflict
    do_reset();
    cycn(3'b001, 5);
    cyc(3'b101, 1'b0);
    expect_lit("brake", 1, 3'b000, 1'b0, 1'b0);
    cycn(3'b011, 3);
    expect_lit("conflict", 1, 3'b000, 1'b0, 1'b0);
    do_reset();
    cycn(3'b010, 2);
    expect_lit("down_at_bot", 0, 3'b010, 1'b0, 1'b0);

    // reset during dead time
    cycn(3'b001, 5);
    cyc(3'b010, 1'b0);
    rst = 1'b1;
    cyc(3'b010, 1'b0);
    expect_lit("rst_dead", 0, 3'b010, 1'b0, 1'b0);
    rst = 1'b0;
    cycn(3'b010, 4);
    expect_lit("rst_dead_after", 0, 3'b010, 1'b0, 1'b0);

    // randomized sticky commands
    rc = 3'b001;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(15) == 0) rc = pick();
      rst = ($urandom_range(500) == 0);
      cyc(rc, ($urandom_range(40) == 0));
    end
    rst = 1'b0;
    cyc(3'b000, 1'b0);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
